// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and digit limits for the stopwatch/timer digit chains.
//   bcd_t          - one 4-bit BCD digit
//   timer_state_t  - countdown timer control states
//   *_MAX          - largest value of each fixed-range digit
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        PAUSE,
        RUN,
        EXPIRED
    } timer_state_t;

    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_ONES_MAX = 4'd9;

endpackage

// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if: control, preset and display bundle of the MM:SS countdown timer.
//   master - button/FSM + display side: drives tick/load/start/stop/clear and presets,
//            reads digits and status
//   slave  - the timer itself
interface bcd_down_timer_if;
    import stopwatch_pkg::*;

    logic tick;
    logic load;
    logic start;
    logic stop;
    logic clear;
    bcd_t pre_min_tens;
    bcd_t pre_min_ones;
    bcd_t pre_sec_tens;
    bcd_t pre_sec_ones;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic running;
    logic expired;
    logic done;
    logic load_err;

    modport master (
        output tick, load, start, stop, clear,
        output pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  running, expired, done, load_err
    );

    modport slave (
        input  tick, load, start, stop, clear,
        input  pre_min_tens, pre_min_ones, pre_sec_tens, pre_sec_ones,
        output min_tens, min_ones, sec_tens, sec_ones,
        output running, expired, done, load_err
    );

endinterface

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one registered BCD digit of a down-counting borrow chain.
//   clk, reset (sync, active-low) - clock and reset (digit clears to 0)
//   borrow_in  - decrement request from the next lower digit (or the tick)
//   load       - overwrite the digit with load_val (wins over borrow_in)
//   digit      - current digit value
//   borrow_out - this digit wrapped 0 -> MAX, so the next higher digit must decrement
//   is_zero    - digit currently reads 0
module bcd_digit_dec
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic reset,
    input  logic borrow_in,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t digit,
    output logic borrow_out,
    output logic is_zero
);

    assign is_zero    = digit == 4'd0;
    assign borrow_out = borrow_in & is_zero;

    always_ff @(posedge clk) begin
        if (!reset)
            digit <= '0;
        else if (load)
            digit <= load_val;
        else if (borrow_in)
            digit <= is_zero ? MAX : digit - 4'd1;
    end

endmodule

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable MM:SS BCD countdown timer, one second per tick.
//   clk    - rising-edge clock
//   reset  - synchronous, active-low reset (IDLE, digits 00:00)
//   bus    - bcd_down_timer_if.slave: tick/load/start/stop/clear, preset digits in,
//            registered digits, running, expired, done pulse, load_err pulse out
//   MIN_TENS_MAX - largest legal minutes-tens digit
// Build option: BCD_DOWN_TIMER_AUTORELOAD_EN reloads the last valid preset on
// reaching 00:00 and keeps running instead of latching EXPIRED.
module bcd_down_timer
    import stopwatch_pkg::*;
#(
    parameter bcd_t MIN_TENS_MAX = 4'd5
) (
    input  logic clk,
    input  logic reset,
    bcd_down_timer_if.slave bus
);

    timer_state_t state, state_d;
    logic [15:0]  preset, pre_q, load_val;
    logic         valid, nonzero, at_one, dec;
    logic         accept, reload, dig_load;
    logic         done_d, err_d, done_q, err_q;
    logic         b_so, b_st, b_mo, unused_b_mt;
    logic         z_st, z_mo, z_mt, unused_z_so;

    assign preset  = {bus.pre_min_tens, bus.pre_min_ones, bus.pre_sec_tens, bus.pre_sec_ones};
    assign valid   = bus.pre_sec_ones <= SEC_ONES_MAX && bus.pre_sec_tens <= SEC_TENS_MAX &&
                     bus.pre_min_ones <= MIN_ONES_MAX && bus.pre_min_tens <= MIN_TENS_MAX;
    assign nonzero = |preset;
    assign dec     = state == RUN && bus.tick;
    // this tick's decrement lands on 00:00
    assign at_one  = z_mt & z_mo & z_st & (bus.sec_ones == 4'd1);

    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        err_d   = 1'b0;
        accept  = 1'b0;
        reload  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
        end else if (bus.load && state != RUN) begin
            accept  = valid;
            err_d   = !valid;
            state_d = !valid ? state : nonzero ? PAUSE : IDLE;
        end else if (state == PAUSE && bus.start) begin
            state_d = RUN;
        end else if (state == RUN) begin
            if (dec && at_one) begin
                done_d = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
                reload  = 1'b1;
                state_d = bus.stop ? PAUSE : RUN;
`else
                state_d = EXPIRED;
`endif
            end else if (bus.stop) begin
                state_d = PAUSE;
            end
        end
    end

    // clear, accepted preset and auto-reload all go through the digits' load port,
    // which overrides the same-cycle decrement
    assign dig_load = bus.clear | accept | reload;
    assign load_val = bus.clear ? 16'h0000 : accept ? preset : pre_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            pre_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            pre_q  <= accept ? preset : pre_q;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    bcd_digit_dec #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .borrow_in(dec), .load(dig_load), .load_val(load_val[3:0]),
        .digit(bus.sec_ones), .borrow_out(b_so), .is_zero(unused_z_so)
    );

    bcd_digit_dec #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .borrow_in(b_so), .load(dig_load), .load_val(load_val[7:4]),
        .digit(bus.sec_tens), .borrow_out(b_st), .is_zero(z_st)
    );

    bcd_digit_dec #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .borrow_in(b_st), .load(dig_load), .load_val(load_val[11:8]),
        .digit(bus.min_ones), .borrow_out(b_mo), .is_zero(z_mo)
    );

    // never borrows below 00:00, so its wrap value and borrow_out are unused
    bcd_digit_dec #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .borrow_in(b_mo), .load(dig_load), .load_val(load_val[15:12]),
        .digit(bus.min_tens), .borrow_out(unused_b_mt), .is_zero(z_mt)
    );

    assign bus.running  = state == RUN;
    assign bus.expired  = state == EXPIRED;
    assign bus.done     = done_q;
    assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed test-plan sequences plus random stimulus against a
// seconds-based reference model; expectations are queued and checked by a monitor.
module tb_bcd_down_timer;

    localparam int MT = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bcd_down_timer_if bif ();

    bcd_down_timer #(.MIN_TENS_MAX(4'd5)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    typedef struct {
        int secs;
        bit run;
        bit exp;
        bit dn;
        bit er;
    } exp_t;

    typedef enum int {M_IDLE, M_PAUSE, M_RUN, M_EXP} mst_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_secs = 0;
    int   m_pre = 0;
    mst_t m_st = M_IDLE;

    function automatic logic [15:0] bcd(int mt, int mo, int st, int so);
        return {4'(mt), 4'(mo), 4'(st), 4'(so)};
    endfunction

    function automatic int digs(int s);
        return int'({4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)});
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // drive one cycle of inputs and queue what the outputs must show after the edge
    task automatic step(bit rs, bit tk, bit ld, bit sa, bit sp, bit cl, logic [15:0] p);
        exp_t e;
        int   a, b, c, d, v;
        bit   dn, er;
        @(negedge clk);
        reset     = rs;
        bif.tick  = tk;
        bif.load  = ld;
        bif.start = sa;
        bif.stop  = sp;
        bif.clear = cl;
        {bif.pre_min_tens, bif.pre_min_ones, bif.pre_sec_tens, bif.pre_sec_ones} = p;
        a  = int'(p[15:12]);
        b  = int'(p[11:8]);
        c  = int'(p[7:4]);
        d  = int'(p[3:0]);
        dn = 1'b0;
        er = 1'b0;
        if (!rs) begin
            m_secs = 0;
            m_pre  = 0;
            m_st   = M_IDLE;
        end else if (cl) begin
            m_secs = 0;
            m_st   = M_IDLE;
        end else if (ld && m_st != M_RUN) begin
            if (a <= MT && b <= 9 && c <= 5 && d <= 9) begin
                v      = a * 600 + b * 60 + c * 10 + d;
                m_secs = v;
                m_pre  = v;
                m_st   = v != 0 ? M_PAUSE : M_IDLE;
            end else begin
                er = 1'b1;
            end
        end else if (m_st == M_PAUSE) begin
            if (sa) m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (tk) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    dn = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
                    m_secs = m_pre;
`else
                    m_st = M_EXP;
`endif
                end
            end
            if (sp && m_st == M_RUN) m_st = M_PAUSE;
        end
        e.secs = m_secs;
        e.run  = m_st == M_RUN;
        e.exp  = m_st == M_EXP;
        e.dn   = dn;
        e.er   = er;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 16'h0000);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("digits", int'({bif.min_tens, bif.min_ones, bif.sec_tens, bif.sec_ones}), digs(e.secs));
                chk("running", int'(bif.running), int'(e.run));
                chk("expired", int'(bif.expired), int'(e.exp));
                chk("done", int'(bif.done), int'(e.dn));
                chk("load_err", int'(bif.load_err), int'(e.er));
            end
        end
    end

    initial begin : stimulus
        int r;
        bif.tick  = 1'b0;
        bif.load  = 1'b0;
        bif.start = 1'b0;
        bif.stop  = 1'b0;
        bif.clear = 1'b0;
        {bif.pre_min_tens, bif.pre_min_ones, bif.pre_sec_tens, bif.pre_sec_ones} = 16'h0000;
        step(0, 0, 0, 0, 0, 0, 16'h0000);
        step(0, 0, 0, 0, 0, 0, 16'h0000);
        idle(1);
        // 01:00 down to 00:00
        step(1, 0, 1, 0, 0, 0, bcd(0, 1, 0, 0));
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        ticks(1);
        idle(1);
        ticks(59);
        idle(2);
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        // rejected presets leave the count alone
        step(1, 0, 1, 0, 0, 0, 16'h005A);
        idle(1);
        step(1, 0, 1, 0, 0, 0, bcd(6, 0, 0, 0));
        idle(1);
        // tick+stop at 10:00
        step(1, 0, 1, 0, 0, 0, bcd(1, 0, 0, 0));
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        step(1, 1, 0, 0, 1, 0, 16'h0000);
        ticks(3);
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        ticks(2);
        // tick+stop at 00:01
        step(1, 0, 0, 0, 0, 1, 16'h0000);
        step(1, 0, 1, 0, 0, 0, bcd(0, 0, 0, 1));
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        step(1, 1, 0, 0, 1, 0, 16'h0000);
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        ticks(2);
        // reset mid-count at 23:45
        step(1, 0, 1, 0, 0, 0, bcd(2, 3, 4, 5));
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        step(1, 0, 1, 0, 0, 0, bcd(0, 0, 0, 7));
        step(0, 1, 0, 0, 0, 0, 16'h0000);
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        ticks(2);
        // 00:02 expiry / auto-reload
        step(1, 0, 1, 0, 0, 0, bcd(0, 0, 0, 2));
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        ticks(2);
        idle(1);
        ticks(2);
        idle(1);
        // zero preset goes to IDLE, start ignored
        step(1, 0, 1, 0, 0, 0, 16'h0000);
        step(1, 0, 0, 1, 0, 0, 16'h0000);
        ticks(1);
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] p;
            r = int'($urandom_range(0, 9));
            p = r < 6 ? bcd(0, 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 9))) :
                r < 8 ? bcd(int'($urandom_range(0, MT)), int'($urandom_range(0, 9)),
                            int'($urandom_range(0, 5)), int'($urandom_range(0, 9))) :
                        16'($urandom);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 59) == 0, p);
        end
        idle(1);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
